// File: rtl/uart_stream_writer.sv
// uart_stream_writer
// AXI4-Lite master that turns a valid/ready byte stream into UART frames.
// After reset it programs the UART's bit timing and stop-bit selection once.
// For each byte it then runs one fixed sequence:
//   write TDR -> enable TX -> poll CFG until TX-done -> disable TX.
// At most one AXI transaction is in flight, and the read and write channels
// are never active at the same time.
module uart_stream_writer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [1:0]  STOP_SEL     = 2'b00,
  parameter int unsigned POLL_GAP     = 8,
  parameter int unsigned MAX_POLLS    = 65535
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  // byte stream in
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        err,
  // AXI4-Lite write address / data / response
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  // AXI4-Lite read address / data
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  // UART register map
  localparam logic [31:0] C_OFF_CPB = 32'h0000_0000;
  localparam logic [31:0] C_OFF_STP = 32'h0000_0004;
  localparam logic [31:0] C_OFF_TDR = 32'h0000_000C;
  localparam logic [31:0] C_OFF_CFG = 32'h0000_0010;

  // CFG values: bit0 = TX enable, bit1 = write-1-to-clear TX flag while
  // preserving the RX flag, bit2 (read) = TX done.
  localparam logic [31:0] C_CFG_TX_OFF = 32'h0000_0002;
  localparam logic [31:0] C_CFG_TX_ON  = 32'h0000_0003;

  localparam logic [31:0] C_CPB_VALUE  = 32'(CLKS_PER_BIT);
  localparam logic [15:0] C_POLL_GAP   = 16'(POLL_GAP);
  localparam logic [15:0] C_MAX_POLLS  = 16'(MAX_POLLS);

  typedef enum logic [3:0] {
    S_INIT_CPB,
    S_INIT_STP,
    S_INIT_CFG,
    S_IDLE,
    S_WR_TDR,
    S_WR_EN,
    S_RD_CFG,
    S_POLL_WAIT,
    S_WR_DIS
  } state_t;

  state_t      r_state;
  // Set once the current state's AXI transaction has been issued; cleared
  // when its final handshake completes so the next state issues afresh.
  logic        r_started;
  logic [7:0]  r_byte;
  logic [15:0] r_poll_cnt;
  logic [15:0] r_gap_cnt;
  logic        r_err;

  logic [31:0] r_awaddr;
  logic        r_awvalid;
  logic [31:0] r_wdata;
  logic        r_wvalid;
  logic        r_bready;
  logic [31:0] r_araddr;
  logic        r_arvalid;
  logic        r_rready;

  logic        w_is_write;
  logic [31:0] w_wr_addr;
  logic [31:0] w_wr_data;
  state_t      w_wr_next;
  logic [15:0] w_poll_next;
  logic        w_poll_limit;
  logic [15:0] w_gap_next;
  logic        w_gap_done;
  logic        w_rd_error;
  logic        w_tx_done;

  // Address, data and successor state for whichever write state is active.
  always_comb begin
    w_is_write = 1'b1;
    w_wr_addr  = BASE_ADDR + C_OFF_CFG;
    w_wr_data  = C_CFG_TX_OFF;
    w_wr_next  = S_IDLE;
    case (r_state)
      S_INIT_CPB: begin
        w_wr_addr = BASE_ADDR + C_OFF_CPB;
        w_wr_data = C_CPB_VALUE;
        w_wr_next = S_INIT_STP;
      end
      S_INIT_STP: begin
        w_wr_addr = BASE_ADDR + C_OFF_STP;
        w_wr_data = {30'b0, STOP_SEL};
        w_wr_next = S_INIT_CFG;
      end
      S_INIT_CFG: begin
        w_wr_addr = BASE_ADDR + C_OFF_CFG;
        w_wr_data = C_CFG_TX_OFF;
        w_wr_next = S_IDLE;
      end
      S_WR_TDR: begin
        w_wr_addr = BASE_ADDR + C_OFF_TDR;
        w_wr_data = {24'b0, r_byte};
        w_wr_next = S_WR_EN;
      end
      S_WR_EN: begin
        w_wr_addr = BASE_ADDR + C_OFF_CFG;
        w_wr_data = C_CFG_TX_ON;
        w_wr_next = S_RD_CFG;
      end
      S_WR_DIS: begin
        w_wr_addr = BASE_ADDR + C_OFF_CFG;
        w_wr_data = C_CFG_TX_OFF;
        w_wr_next = S_IDLE;
      end
      default: begin
        w_is_write = 1'b0;
      end
    endcase
  end

  // Poll bookkeeping: a read that comes back without TX-done counts toward
  // the timeout; the gap counter spaces out successive CFG reads.
  assign w_poll_next  = r_poll_cnt + 16'd1;
  assign w_poll_limit = (w_poll_next >= C_MAX_POLLS);
  assign w_gap_next   = r_gap_cnt + 16'd1;
  assign w_gap_done   = (w_gap_next >= C_POLL_GAP);
  assign w_rd_error   = (m_axi_rresp != 2'b00);
  assign w_tx_done    = m_axi_rdata[2];

  // Only the TX-done bit of CFG is meaningful to this master.
  logic w_unused_rdata;
  assign w_unused_rdata = ^{m_axi_rdata[31:3], m_axi_rdata[1:0]};

  // Sequencer: one state per register access, AXI outputs registered here.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state    <= S_INIT_CPB;
      r_started  <= 1'b0;
      r_byte     <= 8'h00;
      r_poll_cnt <= 16'h0000;
      r_gap_cnt  <= 16'h0000;
      r_err      <= 1'b0;
      r_awaddr   <= 32'h0;
      r_awvalid  <= 1'b0;
      r_wdata    <= 32'h0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_araddr   <= 32'h0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
    end else if (w_is_write) begin
      if (!r_started) begin
        // Address and data go out together; bready stays up until B.
        r_awaddr  <= w_wr_addr;
        r_wdata   <= w_wr_data;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_bready  <= 1'b1;
        r_started <= 1'b1;
      end else begin
        if (r_awvalid && m_axi_awready) begin
          r_awvalid <= 1'b0;
        end
        if (r_wvalid && m_axi_wready) begin
          r_wvalid <= 1'b0;
        end
        if (r_bready && m_axi_bvalid) begin
          r_bready  <= 1'b0;
          r_started <= 1'b0;
          // A slave error is recorded but the sequence still runs to the
          // end so TX is never left enabled.
          if (m_axi_bresp != 2'b00) begin
            r_err <= 1'b1;
          end
          if (r_state == S_WR_TDR) begin
            r_poll_cnt <= 16'h0000;
          end
          r_state <= w_wr_next;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_byte  <= in_data;
            r_state <= S_WR_TDR;
          end
        end
        S_RD_CFG: begin
          if (!r_started) begin
            r_araddr  <= BASE_ADDR + C_OFF_CFG;
            r_arvalid <= 1'b1;
            r_started <= 1'b1;
          end else begin
            if (r_arvalid && m_axi_arready) begin
              r_arvalid <= 1'b0;
              r_rready  <= 1'b1;
            end
            if (r_rready && m_axi_rvalid) begin
              r_rready  <= 1'b0;
              r_started <= 1'b0;
              if (w_rd_error) begin
                // An unreadable CFG is treated as done so TX gets disabled.
                r_err   <= 1'b1;
                r_state <= S_WR_DIS;
              end else if (w_tx_done) begin
                r_state <= S_WR_DIS;
              end else begin
                r_poll_cnt <= w_poll_next;
                if (w_poll_limit) begin
                  r_err   <= 1'b1;
                  r_state <= S_WR_DIS;
                end else begin
                  r_gap_cnt <= 16'h0000;
                  r_state   <= S_POLL_WAIT;
                end
              end
            end
          end
        end
        S_POLL_WAIT: begin
          if (w_gap_done) begin
            r_state <= S_RD_CFG;
          end else begin
            r_gap_cnt <= w_gap_next;
          end
        end
        default: begin
          r_state <= S_INIT_CPB;
        end
      endcase
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign err           = r_err;

  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_uart_stream_writer.sv
// tb_uart_stream_writer
// Directed bench: a behavioural AXI4-Lite UART register slave logs every
// write, answers CFG reads (TX-done after the second read of a byte, or
// never) and can return SLVERR on TDR writes.
module tb_uart_stream_writer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready, busy, err;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  uart_stream_writer #(
    .BASE_ADDR   (32'h0000_0000),
    .CLKS_PER_BIT(16),
    .STOP_SEL    (2'b01),
    .POLL_GAP    (2),
    .MAX_POLLS   (4)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rstn),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .busy         (busy),
    .err          (err),
    .m_axi_awaddr (awaddr),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wvalid (wvalid),
    .m_axi_wready (wready),
    .m_axi_bresp  (bresp),
    .m_axi_bvalid (bvalid),
    .m_axi_bready (bready),
    .m_axi_araddr (araddr),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready)
  );

  // Slave configuration, driven by the stimulus block only.
  bit never_done = 1'b0;
  bit bresp_tdr_err = 1'b0;

  // Slave-side logs and monitors.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int cyc = 0;
  int rd_total = 0;
  int reads_since_tdr = 0;
  int last_r_cyc = 0;
  int min_idle = 999;
  bit have_last = 1'b0;
  int viol = 0;
  int hs_count = 0;

  int n_checks = 0;
  int n_pass = 0;

  assign rresp = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  // UART register slave model plus protocol monitors.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      if (awready && awvalid) begin
        awready <= 1'b0;
        wready  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= (bresp_tdr_err && awaddr == 32'hC) ? 2'b10 : 2'b00;
        wr_addr_q.push_back(awaddr);
        wr_data_q.push_back(wdata);
        if (awaddr == 32'hC) begin
          reads_since_tdr <= 0;
          min_idle        <= 999;
          have_last       <= 1'b0;
        end
      end else if (!awready && !bvalid && awvalid && wvalid) begin
        awready <= 1'b1;
        wready  <= 1'b1;
      end
      if (bvalid && bready) bvalid <= 1'b0;

      if (arready && arvalid) begin
        arready <= 1'b0;
        rvalid  <= 1'b1;
        rdata   <= (!never_done && reads_since_tdr + 1 >= 2) ? 32'h4 : 32'h0;
        reads_since_tdr <= reads_since_tdr + 1;
        rd_total <= rd_total + 1;
      end else if (!arready && !rvalid && arvalid) begin
        arready <= 1'b1;
        if (have_last && (cyc - last_r_cyc - 1) < min_idle)
          min_idle <= cyc - last_r_cyc - 1;
      end
      if (rvalid && rready) begin
        rvalid     <= 1'b0;
        last_r_cyc <= cyc;
        have_last  <= 1'b1;
      end

      viol <= viol + ((((awvalid || wvalid || bready) && (arvalid || rready))) ? 1 : 0)
                   + ((in_ready && busy) ? 1 : 0);
      if (in_valid && in_ready) hs_count <= hs_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, in_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_after_accept", {busy, in_ready}, 2'b10);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_addr"}, wr_addr_q[idx], a);
    check({tag, "_data"}, wr_data_q[idx], d);
  endtask

  initial begin
    int mark;
    int r0;
    int hs0;
    int n;
    logic [7:0] b2b[3];
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h3C;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rstn     = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("rst_ready_busy_err", {in_ready, busy, err}, 3'b010);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_araddr", araddr, 32'h0);

    // Init sequence: CPB, STP, CFG
    rstn = 1'b1;
    wait_idle("init");
    $display("init: %0d writes", wr_addr_q.size());
    check("init_nwr", wr_addr_q.size(), 3);
    check_write("init_cpb", 0, 32'h00, 32'h10);
    check_write("init_stp", 1, 32'h04, 32'h1);
    check_write("init_cfg", 2, 32'h10, 32'h2);
    check("init_busy", busy, 0);
    check("wstrb", wstrb, 4'hF);

    // Single byte 0xA5
    mark = wr_addr_q.size();
    r0 = rd_total;
    send_byte(8'hA5);
    wait_idle("a5");
    $display("byte 0xA5: %0d writes, %0d reads", wr_addr_q.size() - mark, rd_total - r0);
    check("a5_nwr", wr_addr_q.size() - mark, 3);
    check_write("a5_tdr", mark, 32'h0C, 32'hA5);
    check_write("a5_en", mark + 1, 32'h10, 32'h3);
    check_write("a5_dis", mark + 2, 32'h10, 32'h2);
    check("a5_reads", rd_total - r0, 2);
    check("a5_err", err, 0);

    // Back-to-back bytes with in_valid held high
    mark = wr_addr_q.size();
    hs0 = hs_count;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = b2b[i];
      n = 0;
      while (!in_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("b2b_accept", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle("b2b");
    $display("b2b: %0d writes, %0d handshakes", wr_addr_q.size() - mark, hs_count - hs0);
    check("b2b_nwr", wr_addr_q.size() - mark, 9);
    check("b2b_hs", hs_count - hs0, 3);
    for (int i = 0; i < 3; i++) begin
      check_write("b2b_tdr", mark + 3 * i, 32'h0C, {24'b0, b2b[i]});
      check_write("b2b_dis", mark + 3 * i + 2, 32'h10, 32'h2);
    end

    // SLVERR on the TDR write
    bresp_tdr_err = 1'b1;
    mark = wr_addr_q.size();
    send_byte(8'h81);
    wait_idle("bresp");
    bresp_tdr_err = 1'b0;
    $display("bresp: err=%0d, %0d writes", err, wr_addr_q.size() - mark);
    check("bresp_err", err, 1);
    check("bresp_nwr", wr_addr_q.size() - mark, 3);
    check_write("bresp_dis", mark + 2, 32'h10, 32'h2);
    repeat (5) @(negedge clk);
    check("bresp_err_sticky", err, 1);

    // Reset asserted while the TX-enable write is on the bus
    send_byte(8'h42);
    n = 0;
    while (!(awvalid && awaddr == 32'h10 && wdata == 32'h3) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midrst_found_en", awvalid, 1);
    #2;
    rstn = 1'b0;
    #1;
    $display("mid reset: awvalid=%0d busy=%0d err=%0d", awvalid, busy, err);
    check("midrst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("midrst_ready_busy_err", {in_ready, busy, err}, 3'b010);
    @(negedge clk);
    mark = wr_addr_q.size();
    rstn = 1'b1;
    wait_idle("midrst");
    check("midrst_nwr", wr_addr_q.size() - mark, 3);
    check_write("midrst_cpb", mark, 32'h00, 32'h10);
    check_write("midrst_stp", mark + 1, 32'h04, 32'h1);
    check_write("midrst_cfg", mark + 2, 32'h10, 32'h2);

    // Poll timeout: TX-done never set
    never_done = 1'b1;
    mark = wr_addr_q.size();
    r0 = rd_total;
    send_byte(8'h55);
    wait_idle("tmo");
    never_done = 1'b0;
    $display("timeout: %0d reads, min gap %0d, err=%0d", rd_total - r0, min_idle, err);
    check("tmo_reads", rd_total - r0, 4);
    check("tmo_err", err, 1);
    check("tmo_nwr", wr_addr_q.size() - mark, 3);
    check_write("tmo_dis", mark + 2, 32'h10, 32'h2);
    check("tmo_gap_ge2", (min_idle >= 2 && min_idle < 999) ? 1 : 0, 1);

    check("chan_overlap", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
